// File: rtl/vmc_param_ctrl.sv
// Vending-machine controller: coin edge detect, credit accumulation, timed vend strobe, change handshake.
// Optional refund-on-cancel path from COLLECT is built only when VMC_CANCEL_EN is defined.
module vmc_param_ctrl #(
  parameter int PRICE       = 6,
  parameter int CREDIT_W    = 5,
  parameter int VEND_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_1,
  input  logic                coin_2,
  input  logic                coin_5,
  input  logic                coin_10,
  input  logic                cancel,
  input  logic                change_ready,
  output logic                vend,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                busy
);

  // state | meaning
  // IDLE    | no credit, waiting for first coin
  // COLLECT | partial credit below PRICE
  // VEND    | vend strobe held, vend_cnt counts down to 0
  // CHANGE  | change presented until change_ready
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;

  localparam int CNT_W = $clog2(VEND_CYCLES + 1);
  localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);
  localparam logic [CNT_W-1:0] VEND_LOAD = CNT_W'(VEND_CYCLES - 1);

  if (PRICE < 1 || VEND_CYCLES < 1 ||
      (longint'(PRICE) + 9) > ((longint'(1) << CREDIT_W) - 1)) begin : g_param_check
    $error("vmc_param_ctrl: illegal PRICE/CREDIT_W/VEND_CYCLES combination");
  end

  state_t              state, state_nxt;
  logic [3:0]          coin_q, rise;
  logic                any_rise, one_rise, reject_nxt;
  logic [CREDIT_W-1:0] coin_val, credit_sum, credit_nxt, change_nxt;
  logic [CNT_W-1:0]    vend_cnt, vend_cnt_nxt;

  assign rise     = {coin_10, coin_5, coin_2, coin_1} & ~coin_q;
  assign any_rise = |rise;
  assign one_rise = any_rise && ((rise & (rise - 4'd1)) == 4'd0);

  always_comb begin
    coin_val = '0;
    case (rise)
      4'b0001: coin_val = CREDIT_W'(1);
      4'b0010: coin_val = CREDIT_W'(2);
      4'b0100: coin_val = CREDIT_W'(5);
      4'b1000: coin_val = CREDIT_W'(10);
      default: coin_val = '0;
    endcase
  end

  // pre-coin credit is below PRICE, so the parameter check rules out overflow
  assign credit_sum = credit + coin_val;

`ifndef VMC_CANCEL_EN
  logic unused_cancel;
  assign unused_cancel = cancel;
`endif

  always_ff @(posedge clk) begin
    coin_q <= {coin_10, coin_5, coin_2, coin_1};
    if (!rst) begin
      state       <= S_IDLE;
      credit      <= '0;
      change      <= '0;
      coin_reject <= 1'b0;
      vend_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      change      <= change_nxt;
      coin_reject <= reject_nxt;
      vend_cnt    <= vend_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    credit_nxt   = credit;
    change_nxt   = change;
    vend_cnt_nxt = vend_cnt;
    reject_nxt   = any_rise;
    case (state)
      S_IDLE, S_COLLECT: begin
`ifdef VMC_CANCEL_EN
        // cancel beats a simultaneous coin, which is then refused
        if (state == S_COLLECT && cancel) begin
          state_nxt  = S_CHANGE;
          change_nxt = credit;
          credit_nxt = '0;
        end else
`endif
        if (one_rise) begin
          reject_nxt = 1'b0;
          credit_nxt = credit_sum;
          if (credit_sum >= PRICE_W) begin
            state_nxt    = S_VEND;
            vend_cnt_nxt = VEND_LOAD;
          end else begin
            state_nxt = S_COLLECT;
          end
        end
      end
      S_VEND: begin
        if (vend_cnt == '0) begin
          credit_nxt = '0;
          if (credit > PRICE_W) begin
            state_nxt  = S_CHANGE;
            change_nxt = credit - PRICE_W;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          vend_cnt_nxt = vend_cnt - 1'b1;
        end
      end
      S_CHANGE: begin
        if (change_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    vend         = (state == S_VEND);
    change_valid = (state == S_CHANGE);
    busy         = (state == S_VEND) || (state == S_CHANGE);
  end

endmodule

// File: tb/tb_vmc_param_ctrl.sv
// Scoreboarded bench for vmc_param_ctrl: directed corners plus random coin/cancel traffic.
module tb_vmc_param_ctrl;
  localparam int PRICE = 6;
  localparam int CREDIT_W = 5;
  localparam int VEND_CYCLES = 3;
`ifdef VMC_CANCEL_EN
  localparam bit CANCEL_ON = 1'b1;
`else
  localparam bit CANCEL_ON = 1'b0;
`endif
  localparam int EV_VEND = 0, EV_CHANGE = 1, EV_REJECT = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic coin_1 = 0, coin_2 = 0, coin_5 = 0, coin_10 = 0, cancel = 0, change_ready = 0;
  logic vend, change_valid, coin_reject, busy;
  logic [CREDIT_W-1:0] change, credit;

  vmc_param_ctrl #(.PRICE(PRICE), .CREDIT_W(CREDIT_W), .VEND_CYCLES(VEND_CYCLES)) dut (
    .clk(clk), .rst(rst), .coin_1(coin_1), .coin_2(coin_2), .coin_5(coin_5),
    .coin_10(coin_10), .cancel(cancel), .change_ready(change_ready), .vend(vend),
    .change_valid(change_valid), .change(change), .credit(credit),
    .coin_reject(coin_reject), .busy(busy));

  always #5 clk = ~clk;

  typedef struct { int kind; int val; } ev_t;
  ev_t sbq[$];
  int n_cmp = 0, n_fail = 0;
  int m_credit = 0;
  bit rnd_ready = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind; e.val = val;
    sbq.push_back(e);
  endtask

  task automatic expect_ev(input int kind, output int val);
    ev_t e;
    if (sbq.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL sb_unexpected: got event kind %0d expected none at %0t", kind, $time);
      val = -1;
    end else begin
      e = sbq.pop_front();
      chk("sb_kind", kind, e.kind);
      val = e.val;
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents an event
  initial begin
    bit vend_prev = 0, hold_pending = 0;
    int vlen = 0, exp_len = 0, hold_val = 0, v;
    forever begin
      @(negedge clk); #1;
      if (vend) begin
        if (!vend_prev) begin expect_ev(EV_VEND, v); exp_len = v; vlen = 0; end
        vlen++;
      end else if (vend_prev) chk("vend_len", vlen, exp_len);
      vend_prev = vend;
      if (coin_reject) expect_ev(EV_REJECT, v);
      if (change_valid) begin
        if (hold_pending) chk("change_hold", int'(change), hold_val);
        if (change_ready) begin
          expect_ev(EV_CHANGE, v);
          chk("change_amt", int'(change), v);
          hold_pending = 0;
        end else begin
          hold_pending = 1; hold_val = int'(change);
        end
      end else hold_pending = 0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rnd_ready) change_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic set_coins(input logic [3:0] m);
    {coin_10, coin_5, coin_2, coin_1} = m;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  // one stimulus step with reference model: mask of coins rising, optional cancel
  task automatic apply(input logic [3:0] mask, input bit canc);
    int vals[4] = '{1, 2, 5, 10};
    int n = $countones(mask), shown, val = 0;
    bit trans = 0;
    for (int i = 0; i < 4; i++) if (mask[i]) val = vals[i];
    if (CANCEL_ON && canc && m_credit > 0) begin
      if (n > 0) push(EV_REJECT, 0);
      push(EV_CHANGE, m_credit);
      m_credit = 0; shown = 0; trans = 1;
    end else if (n > 1) begin
      push(EV_REJECT, 0); shown = m_credit;
    end else begin
      m_credit += val; shown = m_credit;
      if (m_credit >= PRICE) begin
        push(EV_VEND, VEND_CYCLES);
        if (m_credit > PRICE) push(EV_CHANGE, m_credit - PRICE);
        m_credit = 0; trans = 1;
      end
    end
    @(negedge clk); set_coins(mask); cancel = canc;
    @(negedge clk); set_coins(4'b0); cancel = 1'b0;
    chk("credit", int'(credit), shown);
    if (trans) wait_idle();
  endtask

  initial begin
    int cnt, n;
    logic [3:0] m;
    repeat (3) @(negedge clk);
    chk("rst_vend", int'(vend), 0);
    chk("rst_change_valid", int'(change_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_coin_reject", int'(coin_reject), 0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_change", int'(change), 0);
    rst = 1'b1;

    apply(4'b0100, 0);
    apply(4'b0010, 0);

    // backpressure: ready low for 4 change cycles
    rnd_ready = 0; change_ready = 0;
    push(EV_VEND, VEND_CYCLES); push(EV_CHANGE, 4);
    apply_raw10: begin
      @(negedge clk); set_coins(4'b1000);
      @(negedge clk); set_coins(4'b0000);
      chk("credit_bp", int'(credit), 10);
      n = 0;
      while (!change_valid && n < 20) begin @(negedge clk); n++; end
      cnt = 0;
      repeat (4) begin if (change_valid) cnt++; @(negedge clk); end
      chk("bp_valid_cycles", cnt, 4);
      change_ready = 1;
      @(negedge clk); change_ready = 0;
      chk("bp_released", int'(change_valid), 0);
    end
    rnd_ready = 1;

    apply(4'b0010, 0); apply(4'b0010, 0); apply(4'b0010, 0);
    apply(4'b0101, 0);

    // coin_2 rising during VEND is refused
    push(EV_VEND, VEND_CYCLES); push(EV_REJECT, 0); push(EV_CHANGE, 4);
    @(negedge clk); set_coins(4'b1000);
    @(negedge clk); set_coins(4'b0010);
    @(negedge clk); set_coins(4'b0000);
    wait_idle();

    // coin held through reset is not counted
    @(negedge clk); set_coins(4'b0100); rst = 0;
    @(negedge clk);
    @(negedge clk); rst = 1;
    @(negedge clk);
    @(negedge clk); set_coins(4'b0000);
    chk("credit_held_coin", int'(credit), 0);

    // reset in the second vend cycle drops the transaction
    push(EV_VEND, 2);
    @(negedge clk); set_coins(4'b1000);
    @(negedge clk); set_coins(4'b0000);
    @(negedge clk); rst = 0;
    @(negedge clk);
    chk("abort_vend", int'(vend), 0);
    chk("abort_change_valid", int'(change_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_credit", int'(credit), 0);
    rst = 1;
    m_credit = 0;
    @(negedge clk); #2;
    chk("abort_no_change", int'(change_valid), 0);

    apply(4'b0100, 0);
    apply(4'b0000, 1);

    for (int i = 0; i < 200; i++) begin
      int r = $urandom_range(0, 9);
      if (r == 0) begin
        m = 4'(1 << $urandom_range(0, 3));
        m = m | 4'(1 << $urandom_range(0, 3));
        if ($countones(m) < 2) m = m | ((m == 4'b0001) ? 4'b0010 : 4'b0001);
        apply(m, 0);
      end else if (r == 1) begin
        m = ($urandom_range(0, 1) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
        apply(m, 1);
      end else begin
        apply(4'(1 << $urandom_range(0, 3)), 0);
      end
    end

    repeat (10) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end
endmodule
